// File: rtl/moore_seq_detector.sv
// Moore serial sequence detector with a runtime-loadable pattern.
// Overlapping and non-overlapping detection, with a saturating match counter.
module moore_seq_detector #(
  parameter int                   PAT_WIDTH     = 4,
  parameter int                   CNT_WIDTH     = 8,
  parameter logic [PAT_WIDTH-1:0] RESET_PATTERN = 4'b1101
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 i,
  input  logic                 pattern_load,
  input  logic [PAT_WIDTH-1:0] pattern_in,
  input  logic                 overlap_en,
  input  logic                 count_clear,
  output logic                 o,
  output logic [CNT_WIDTH-1:0] match_count
);

  localparam int             FW   = $clog2(PAT_WIDTH + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_WIDTH);

  logic [PAT_WIDTH-1:0] pattern;
  logic [PAT_WIDTH-1:0] history;
  logic [FW-1:0]        fill;

  logic [PAT_WIDTH-1:0] hist_shift;
  logic [FW-1:0]        fill_inc;
  logic                 match;
  logic                 cnt_sat;

  // Next-state terms for one sampled bit; a match requires a full window.
  always_comb begin
    hist_shift = {history[PAT_WIDTH-2:0], i};
    fill_inc   = (fill == FULL) ? fill : fill + 1'b1;
    match      = en && !pattern_load && (fill_inc == FULL) && (hist_shift == pattern);
    cnt_sat    = &match_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= RESET_PATTERN;
      history <= '0;
      fill    <= '0;
      o       <= 1'b0;
    end else begin
      // o is the registered match strobe; any non-matching edge clears it.
      o <= match;
      if (pattern_load) begin
        pattern <= pattern_in;
        history <= '0;
        fill    <= '0;
      end else if (en) begin
        history <= hist_shift;
        fill    <= (match && !overlap_en) ? '0 : fill_inc;
      end
    end
  end

  // Clear wins over a coincident match; count never wraps.
  always_ff @(posedge clk) begin
    if (rst || count_clear)
      match_count <= '0;
    else if (match && !cnt_sat)
      match_count <= match_count + 1'b1;
  end

endmodule
